// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: the driver side is the master,
// the counter itself is the slave.
interface updown_mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             CLR;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic             CE;
  logic             CI;
  logic             M;
  logic             SAT;
  logic [WIDTH-1:0] LIMIT;
  logic             CLR_OVF;
  logic [WIDTH-1:0] Q;
  logic             CO;
  logic             OVF;
  logic             TC;

  modport master (
    output CLR, LD, D, CE, CI, M, SAT, LIMIT, CLR_OVF,
    input  Q, CO, OVF, TC
  );

  modport slave (
    input  CLR, LD, D, CE, CI, M, SAT, LIMIT, CLR_OVF,
    output Q, CO, OVF, TC
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..LIMIT with load, wrap/saturate, sticky overflow
// and a combinational terminal count for chaining TC into the next CI.
module updown_mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic CLK,
  input  logic RST_,
  updown_mod_counter_if.slave bus
);

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic             r_ovf;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_co_nxt;
  logic             w_ovf_nxt;
  logic             w_bound;
  logic             w_step;
  logic [WIDTH-1:0] w_ld_val;

  assign w_step   = bus.CE & bus.CI;
  assign w_ld_val = (bus.D > bus.LIMIT) ? bus.LIMIT : bus.D;

  always_comb begin
    w_q_nxt   = r_q;
    w_co_nxt  = 1'b0;
    w_bound   = 1'b0;
    w_ovf_nxt = r_ovf & ~bus.CLR_OVF;
    if (bus.CLR) begin
      w_q_nxt   = '0;
      w_ovf_nxt = 1'b0;
    end else if (bus.LD) begin
      w_q_nxt = w_ld_val;
    end else if (w_step) begin
      if (!bus.M) begin
        // Q above a lowered LIMIT still counts as the upper boundary
        if (r_q < bus.LIMIT) begin
          w_q_nxt = r_q + WIDTH'(1);
        end else begin
          w_bound  = 1'b1;
          w_q_nxt  = bus.SAT ? bus.LIMIT : '0;
          w_co_nxt = ~bus.SAT;
        end
      end else begin
        if (r_q > bus.LIMIT) begin
          w_q_nxt = bus.LIMIT;
        end else if (r_q != '0) begin
          w_q_nxt = r_q - WIDTH'(1);
        end else begin
          w_bound  = 1'b1;
          w_q_nxt  = bus.SAT ? '0 : bus.LIMIT;
          w_co_nxt = ~bus.SAT;
        end
      end
      // a boundary event wins over a simultaneous sticky clear
      if (w_bound) begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      r_q   <= '0;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_co  <= w_co_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign bus.Q   = r_q;
  assign bus.CO  = r_co;
  assign bus.OVF = r_ovf;
  assign bus.TC  = bus.CI & (bus.M ? (r_q == '0) : (r_q >= bus.LIMIT));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: two cascaded instances, a behavioural model
// checked every cycle, directed scenarios and randomized traffic.
module tb_updown_mod_counter;
  localparam int W = 8;

  logic CLK;
  logic RST_;
  bit   chk_en;
  int   n_cmp;
  int   n_bad;

  updown_mod_counter_if #(.WIDTH(W)) lo_if ();
  updown_mod_counter_if #(.WIDTH(W)) hi_if ();

  assign hi_if.CI = lo_if.TC;

  updown_mod_counter #(.WIDTH(W)) u_lo (.CLK(CLK), .RST_(RST_), .bus(lo_if));
  updown_mod_counter #(.WIDTH(W)) u_hi (.CLK(CLK), .RST_(RST_), .bus(hi_if));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // model state: index 0 = low stage, 1 = high stage
  int mq [2];
  int mco [2];
  int movf [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mco[i] = 0; movf[i] = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tcm(input int q, input int ci, input int m, input int lim);
    if (ci == 0) return 0;
    if (m != 0) return (q == 0) ? 1 : 0;
    return (q >= lim) ? 1 : 0;
  endfunction

  function automatic void mstep(input int q, input int ovf, input int clr, input int ld,
                                input int ce, input int ci, input int m, input int sat,
                                input int covf, input int d, input int lim,
                                output int nq, output int nco, output int novf);
    int ev;
    ev   = 0;
    nq   = q;
    nco  = 0;
    novf = (ovf != 0 && covf == 0) ? 1 : 0;
    if (clr != 0) begin
      nq   = 0;
      novf = 0;
    end else if (ld != 0) begin
      nq = (d > lim) ? lim : d;
    end else if (ce != 0 && ci != 0) begin
      if (m == 0) begin
        if (q < lim) nq = q + 1;
        else begin ev = 1; nq = (sat != 0) ? lim : 0; end
      end else begin
        if (q > lim) nq = lim;
        else if (q > 0) nq = q - 1;
        else begin ev = 1; nq = (sat != 0) ? 0 : lim; end
      end
    end
    if (ev != 0) begin
      novf = 1;
      nco  = (sat != 0) ? 0 : 1;
    end
  endfunction

  always @(posedge CLK or negedge RST_) begin
    int q0, c0, o0, q1, c1, o1, ltc;
    if (!RST_) begin
      for (int i = 0; i < 2; i++) begin
        mq[i] = 0; mco[i] = 0; movf[i] = 0;
      end
    end else begin
      ltc = tcm(mq[0], int'(lo_if.CI), int'(lo_if.M), int'(lo_if.LIMIT));
      mstep(mq[0], movf[0], int'(lo_if.CLR), int'(lo_if.LD), int'(lo_if.CE), int'(lo_if.CI),
            int'(lo_if.M), int'(lo_if.SAT), int'(lo_if.CLR_OVF), int'(lo_if.D),
            int'(lo_if.LIMIT), q0, c0, o0);
      mstep(mq[1], movf[1], int'(hi_if.CLR), int'(hi_if.LD), int'(hi_if.CE), ltc,
            int'(hi_if.M), int'(hi_if.SAT), int'(hi_if.CLR_OVF), int'(hi_if.D),
            int'(hi_if.LIMIT), q1, c1, o1);
      mq[0] = q0; mco[0] = c0; movf[0] = o0;
      mq[1] = q1; mco[1] = c1; movf[1] = o1;
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    int ltc;
    if (chk_en) begin
      ltc = tcm(mq[0], int'(lo_if.CI), int'(lo_if.M), int'(lo_if.LIMIT));
      chk("lo_Q",   int'(lo_if.Q),   mq[0]);
      chk("lo_CO",  int'(lo_if.CO),  mco[0]);
      chk("lo_OVF", int'(lo_if.OVF), movf[0]);
      chk("lo_TC",  int'(lo_if.TC),  ltc);
      chk("hi_Q",   int'(hi_if.Q),   mq[1]);
      chk("hi_CO",  int'(hi_if.CO),  mco[1]);
      chk("hi_OVF", int'(hi_if.OVF), movf[1]);
      chk("hi_TC",  int'(hi_if.TC),
          tcm(mq[1], ltc, int'(hi_if.M), int'(hi_if.LIMIT)));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_inputs();
    lo_if.CLR = 0; lo_if.LD = 0; lo_if.D = '0; lo_if.CE = 0; lo_if.CI = 1;
    lo_if.M = 0; lo_if.SAT = 0; lo_if.LIMIT = 8'd255; lo_if.CLR_OVF = 0;
    hi_if.CLR = 0; hi_if.LD = 0; hi_if.D = '0; hi_if.CE = 0;
    hi_if.M = 0; hi_if.SAT = 0; hi_if.LIMIT = 8'd255; hi_if.CLR_OVF = 0;
  endtask

  task automatic rand_inputs(input bit new_lim);
    lo_if.CLR     = ($urandom_range(0, 31) == 0);
    lo_if.LD      = ($urandom_range(0, 7) == 0);
    lo_if.D       = W'($urandom);
    lo_if.CE      = ($urandom_range(0, 3) != 0);
    lo_if.CI      = ($urandom_range(0, 7) != 0);
    lo_if.M       = W'($urandom) < 8'd128;
    lo_if.SAT     = $urandom_range(0, 1) == 1;
    lo_if.CLR_OVF = ($urandom_range(0, 7) == 0);
    hi_if.CLR     = ($urandom_range(0, 31) == 0);
    hi_if.LD      = ($urandom_range(0, 15) == 0);
    hi_if.D       = W'($urandom);
    hi_if.CE      = ($urandom_range(0, 3) != 0);
    hi_if.M       = $urandom_range(0, 1) == 1;
    hi_if.SAT     = $urandom_range(0, 1) == 1;
    hi_if.CLR_OVF = ($urandom_range(0, 7) == 0);
    if (new_lim) begin
      case ($urandom_range(0, 3))
        0:       lo_if.LIMIT = '0;
        1:       lo_if.LIMIT = 8'd255;
        2:       lo_if.LIMIT = W'($urandom_range(1, 6));
        default: lo_if.LIMIT = W'($urandom);
      endcase
      hi_if.LIMIT = W'($urandom_range(0, 9));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_en = 0;
    RST_   = 1;
    idle_inputs();
    #1 RST_ = 0;
    chk_en = 1;
    repeat (2) @(posedge CLK);
    #2 RST_ = 1;
    chk("rst_Q", int'(lo_if.Q), 0);
    chk("rst_OVF", int'(lo_if.OVF), 0);

    // wrap at LIMIT=9 going up
    lo_if.LIMIT = 8'd9; lo_if.LD = 1; lo_if.D = 8'd7;
    tick(); chk("t2_ld", int'(lo_if.Q), 7);
    lo_if.LD = 0; lo_if.CE = 1;
    tick(); chk("t2_q8", int'(lo_if.Q), 8);
    tick(); chk("t2_q9", int'(lo_if.Q), 9);
    #1 chk("t2_tc", int'(lo_if.TC), 1);
    chk("t2_co9", int'(lo_if.CO), 0);
    tick(); chk("t2_q0", int'(lo_if.Q), 0);
    chk("t2_co", int'(lo_if.CO), 1);
    chk("t2_ovf", int'(lo_if.OVF), 1);
    lo_if.CE = 0;
    tick(); chk("t2_co_drop", int'(lo_if.CO), 0);

    // asynchronous reset in the middle of a cycle
    lo_if.LIMIT = 8'd255; lo_if.LD = 1; lo_if.D = 8'h37;
    tick(); lo_if.LD = 0;
    chk("t1_q37", int'(lo_if.Q), 8'h37);
    #1 RST_ = 0;
    #1 chk("t1_rq", int'(lo_if.Q), 0);
    chk("t1_rco", int'(lo_if.CO), 0);
    chk("t1_rovf", int'(lo_if.OVF), 0);
    lo_if.M = 1;
    #1 chk("t1_tc_dn", int'(lo_if.TC), 1);
    lo_if.M = 0;
    #1 chk("t1_tc_up", int'(lo_if.TC), 0);
    RST_ = 1;
    tick();

    // saturate at 0 going down, then clear the sticky flag
    lo_if.LIMIT = 8'd200; lo_if.SAT = 1; lo_if.M = 1; lo_if.LD = 1; lo_if.D = 8'd2;
    tick(); chk("t3_ld", int'(lo_if.Q), 2);
    lo_if.LD = 0; lo_if.CE = 1;
    tick(); chk("t3_q1", int'(lo_if.Q), 1);
    tick(); chk("t3_q0", int'(lo_if.Q), 0);
    chk("t3_ovf0", int'(lo_if.OVF), 0);
    tick(); chk("t3_sat", int'(lo_if.Q), 0);
    chk("t3_ovf1", int'(lo_if.OVF), 1);
    chk("t3_co", int'(lo_if.CO), 0);
    tick(); chk("t3_sat2", int'(lo_if.Q), 0);
    lo_if.CE = 0; lo_if.CLR_OVF = 1;
    tick(); chk("t3_clrovf", int'(lo_if.OVF), 0);
    lo_if.CLR_OVF = 0;

    // load clamp, then lowered LIMIT pulls Q down
    lo_if.LIMIT = 8'd50; lo_if.LD = 1; lo_if.D = 8'd200; lo_if.SAT = 0; lo_if.M = 0;
    tick(); chk("t4_clamp", int'(lo_if.Q), 50);
    lo_if.LD = 0; lo_if.LIMIT = 8'd20; lo_if.M = 1; lo_if.CE = 1;
    tick(); chk("t4_lower", int'(lo_if.Q), 20);
    chk("t4_co", int'(lo_if.CO), 0);
    lo_if.CE = 0;

    // CLR beats LD; boundary beats CLR_OVF
    lo_if.CLR = 1; lo_if.LD = 1; lo_if.D = 8'd5;
    tick(); chk("t5_clr", int'(lo_if.Q), 0);
    lo_if.CLR = 0; lo_if.LD = 0; lo_if.CE = 1; lo_if.CLR_OVF = 1;
    tick(); chk("t5_wrapq", int'(lo_if.Q), 20);
    chk("t5_co", int'(lo_if.CO), 1);
    chk("t5_ovf", int'(lo_if.OVF), 1);
    lo_if.CE = 0; lo_if.CLR_OVF = 0;
    tick();

    // two-stage cascade
    idle_inputs();
    lo_if.CLR = 1; hi_if.CLR = 1;
    tick();
    lo_if.CLR = 0; hi_if.CLR = 0; lo_if.CE = 1; hi_if.CE = 1;
    repeat (256) tick();
    chk("t6_lo", int'(lo_if.Q), 0);
    chk("t6_hi", int'(hi_if.Q), 1);
    lo_if.M = 1; hi_if.M = 1;
    tick();
    chk("t6_lo_dn", int'(lo_if.Q), 255);
    chk("t6_hi_dn", int'(hi_if.Q), 0);
    idle_inputs();
    tick();

    // randomized traffic with occasional mid-cycle resets
    for (int k = 0; k < 4000; k++) begin
      tick();
      if ($urandom_range(0, 199) == 0) begin
        #1 RST_ = 0;
        #1 RST_ = 1;
      end
      rand_inputs(k == 0 || $urandom_range(0, 15) == 0);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
